// File: rtl/arc_pkg.sv
// Shared constants and helpers for the MIPS core's hazard/forwarding logic.
// Holds the forward-select encodings, default HI/LO latencies and register-match rules.
package arc_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != REG_ZERO);
    endfunction

    function automatic logic [1:0] ex_fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_regwrite,
        input logic [4:0] wb_rd,
        input logic       wb_regwrite
    );
        if (mem_regwrite && reg_match(src, mem_rd))
            return FWD_MEM;
        else if (wb_regwrite && reg_match(src, wb_rd))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// HI/LO unit occupancy tracker: loads the mult/div latency on a start and counts down.
// Busy is taken straight from the counter register, so it drops immediately on reset.
module md_busy_counter
    import arc_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    logic [CW-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (count_q == '0) begin
            if (i_start)
                count_q <= i_is_div ? DIV_LOAD : MULT_LOAD;
        end else begin
            // A start arriving while busy is ignored; the ID interlock should prevent it.
            count_q <= count_q - CW'(1);
        end
    end

    assign o_busy = (count_q != '0);

endmodule

// File: rtl/d_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage MIPS pipeline: stall, bubble,
// flush and forward selects for IF/ID/EX, plus the HI/LO busy interlock and stall counter.
module d_hazard_ctrl
    import arc_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_use_rs,
    input  logic        i_id_use_rt,
    input  logic        i_id_is_branch,
    input  logic        i_id_redirect,
    input  logic        i_id_md_use,
    input  logic [4:0]  i_ex_rs,
    input  logic [4:0]  i_ex_rt,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_memread,
    input  logic        i_ex_md_start,
    input  logic        i_ex_md_is_div,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_regwrite,
    input  logic        i_mem_memread,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    output logic        o_stall_f,
    output logic        o_stall_d,
    output logic        o_bubble_e,
    output logic        o_flush_d,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic        o_fwd_br_a,
    output logic        o_fwd_br_b,
    output logic        o_md_busy,
    output logic [15:0] o_stall_count
);

    logic md_busy;
    logic src_hits_ex;
    logic src_hits_mem;
    logic load_use;
    logic br_hazard;
    logic md_hazard;
    logic stall;
    logic [15:0] stall_count_q;

    md_busy_counter #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_busy (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_ex_md_start),
        .i_is_div(i_ex_md_is_div),
        .o_busy  (md_busy)
    );

    assign src_hits_ex  = (i_id_use_rs && reg_match(i_id_rs, i_ex_rd)) ||
                          (i_id_use_rt && reg_match(i_id_rt, i_ex_rd));
    assign src_hits_mem = (i_id_use_rs && reg_match(i_id_rs, i_mem_rd)) ||
                          (i_id_use_rt && reg_match(i_id_rt, i_mem_rd));

    assign load_use  = i_ex_memread && i_ex_regwrite && src_hits_ex;
    // Branches compare in ID, so any EX producer or a MEM load is still too late.
    assign br_hazard = i_id_is_branch &&
                       ((i_ex_regwrite && src_hits_ex) || (i_mem_memread && src_hits_mem));
    assign md_hazard = i_id_md_use && md_busy;
    assign stall     = i_rst_n && (load_use || br_hazard || md_hazard);

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        o_stall_f  = 1'b0;
        o_stall_d  = 1'b0;
        o_bubble_e = 1'b0;
        o_flush_d  = 1'b0;
        o_fwd_a    = FWD_REG;
        o_fwd_b    = FWD_REG;
        o_fwd_br_a = 1'b0;
        o_fwd_br_b = 1'b0;
        if (i_rst_n) begin
            o_stall_f  = stall;
            o_stall_d  = stall;
            o_bubble_e = stall;
            // A stalled redirect is re-evaluated when the ID instruction retries.
            o_flush_d  = i_id_redirect && !stall;
            o_fwd_a    = ex_fwd_sel(i_ex_rs, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
            o_fwd_b    = ex_fwd_sel(i_ex_rt, i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite);
            o_fwd_br_a = i_id_use_rs && i_mem_regwrite && !i_mem_memread &&
                         reg_match(i_id_rs, i_mem_rd);
            o_fwd_br_b = i_id_use_rt && i_mem_regwrite && !i_mem_memread &&
                         reg_match(i_id_rt, i_mem_rd);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_count_q <= '0;
        else if (stall && (stall_count_q != 16'hFFFF))
            stall_count_q <= stall_count_q + 16'd1;
    end

    assign o_md_busy     = md_busy;
    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Scoreboard bench for d_hazard_ctrl: each driven cycle pushes a predicted output set,
// which is popped and compared on the following falling edge.
module tb_d_hazard_ctrl;
    import arc_pkg::*;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       id_use_rs, id_use_rt, id_is_branch, id_redirect, id_md_use;
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic       ex_regwrite, ex_memread, ex_md_start, ex_md_is_div;
        logic [4:0] mem_rd;
        logic       mem_regwrite, mem_memread;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
    } stim_t;

    typedef struct packed {
        logic        stall_f, stall_d, bubble_e, flush_d;
        logic [1:0]  fwd_a, fwd_b;
        logic        fwd_br_a, fwd_br_b, md_busy;
        logic [15:0] stall_count;
    } outs_t;

    logic        i_clk, i_rst_n;
    logic [4:0]  i_id_rs, i_id_rt, i_ex_rs, i_ex_rt, i_ex_rd, i_mem_rd, i_wb_rd;
    logic        i_id_use_rs, i_id_use_rt, i_id_is_branch, i_id_redirect, i_id_md_use;
    logic        i_ex_regwrite, i_ex_memread, i_ex_md_start, i_ex_md_is_div;
    logic        i_mem_regwrite, i_mem_memread, i_wb_regwrite;
    logic        o_stall_f, o_stall_d, o_bubble_e, o_flush_d, o_fwd_br_a, o_fwd_br_b, o_md_busy;
    logic [1:0]  o_fwd_a, o_fwd_b;
    logic [15:0] o_stall_count;

    d_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
        .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt),
        .i_id_is_branch(i_id_is_branch), .i_id_redirect(i_id_redirect),
        .i_id_md_use(i_id_md_use),
        .i_ex_rs(i_ex_rs), .i_ex_rt(i_ex_rt), .i_ex_rd(i_ex_rd),
        .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread),
        .i_ex_md_start(i_ex_md_start), .i_ex_md_is_div(i_ex_md_is_div),
        .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite), .i_mem_memread(i_mem_memread),
        .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
        .o_stall_f(o_stall_f), .o_stall_d(o_stall_d), .o_bubble_e(o_bubble_e),
        .o_flush_d(o_flush_d), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b),
        .o_fwd_br_a(o_fwd_br_a), .o_fwd_br_b(o_fwd_br_b),
        .o_md_busy(o_md_busy), .o_stall_count(o_stall_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    outs_t sb_q[$];
    int    m_md = 0;
    int    m_sc = 0;
    logic  obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != 5'd0);
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // Reference behaviour written from the hazard rules, independent of the RTL structure.
    function automatic outs_t predict(input stim_t s, input int md, input int sc);
        outs_t e;
        logic  rs_ex, rt_ex, rs_mem, rt_mem, stl;
        rs_ex  = s.id_use_rs && hit(s.id_rs, s.ex_rd);
        rt_ex  = s.id_use_rt && hit(s.id_rt, s.ex_rd);
        rs_mem = s.id_use_rs && hit(s.id_rs, s.mem_rd);
        rt_mem = s.id_use_rt && hit(s.id_rt, s.mem_rd);
        stl = 1'b0;
        if (s.ex_memread && s.ex_regwrite && (rs_ex || rt_ex)) stl = 1'b1;
        if (s.id_is_branch && s.ex_regwrite && (rs_ex || rt_ex)) stl = 1'b1;
        if (s.id_is_branch && s.mem_memread && (rs_mem || rt_mem)) stl = 1'b1;
        if (s.id_md_use && md != 0) stl = 1'b1;
        e = '0;
        e.stall_f  = stl;
        e.stall_d  = stl;
        e.bubble_e = stl;
        e.flush_d  = s.id_redirect && !stl;
        if (s.mem_regwrite && hit(s.ex_rs, s.mem_rd))     e.fwd_a = FWD_MEM;
        else if (s.wb_regwrite && hit(s.ex_rs, s.wb_rd))  e.fwd_a = FWD_WB;
        if (s.mem_regwrite && hit(s.ex_rt, s.mem_rd))     e.fwd_b = FWD_MEM;
        else if (s.wb_regwrite && hit(s.ex_rt, s.wb_rd))  e.fwd_b = FWD_WB;
        e.fwd_br_a    = rs_mem && s.mem_regwrite && !s.mem_memread;
        e.fwd_br_b    = rt_mem && s.mem_regwrite && !s.mem_memread;
        e.md_busy     = (md != 0);
        e.stall_count = 16'(sc);
        return e;
    endfunction

    task automatic advance(input stim_t s, input logic stl);
        if (m_md == 0) begin
            if (s.ex_md_start) m_md = s.ex_md_is_div ? DIV_N : MULT_N;
        end else begin
            m_md = m_md - 1;
        end
        if (stl && m_sc < 65535) m_sc = m_sc + 1;
    endtask

    task automatic drive(input stim_t s);
        i_id_rs = s.id_rs;               i_id_rt = s.id_rt;
        i_id_use_rs = s.id_use_rs;       i_id_use_rt = s.id_use_rt;
        i_id_is_branch = s.id_is_branch; i_id_redirect = s.id_redirect;
        i_id_md_use = s.id_md_use;
        i_ex_rs = s.ex_rs;               i_ex_rt = s.ex_rt;   i_ex_rd = s.ex_rd;
        i_ex_regwrite = s.ex_regwrite;   i_ex_memread = s.ex_memread;
        i_ex_md_start = s.ex_md_start;   i_ex_md_is_div = s.ex_md_is_div;
        i_mem_rd = s.mem_rd;             i_mem_regwrite = s.mem_regwrite;
        i_mem_memread = s.mem_memread;
        i_wb_rd = s.wb_rd;               i_wb_regwrite = s.wb_regwrite;
    endtask

    function automatic outs_t sample();
        outs_t g;
        g.stall_f = o_stall_f;   g.stall_d = o_stall_d;   g.bubble_e = o_bubble_e;
        g.flush_d = o_flush_d;   g.fwd_a = o_fwd_a;       g.fwd_b = o_fwd_b;
        g.fwd_br_a = o_fwd_br_a; g.fwd_br_b = o_fwd_br_b; g.md_busy = o_md_busy;
        g.stall_count = o_stall_count;
        return g;
    endfunction

    task automatic compare(input string tag, input outs_t g, input outs_t e);
        check({tag, "/stall_f"},  32'(g.stall_f),     32'(e.stall_f));
        check({tag, "/stall_d"},  32'(g.stall_d),     32'(e.stall_d));
        check({tag, "/bubble_e"}, 32'(g.bubble_e),    32'(e.bubble_e));
        check({tag, "/flush_d"},  32'(g.flush_d),     32'(e.flush_d));
        check({tag, "/fwd_a"},    32'(g.fwd_a),       32'(e.fwd_a));
        check({tag, "/fwd_b"},    32'(g.fwd_b),       32'(e.fwd_b));
        check({tag, "/fwd_br_a"}, 32'(g.fwd_br_a),    32'(e.fwd_br_a));
        check({tag, "/fwd_br_b"}, 32'(g.fwd_br_b),    32'(e.fwd_br_b));
        check({tag, "/md_busy"},  32'(g.md_busy),     32'(e.md_busy));
        check({tag, "/stall_cnt"}, 32'(g.stall_count), 32'(e.stall_count));
    endtask

    // Called just after a rising edge; returns just after the next rising edge.
    task automatic step(input stim_t s, input string tag);
        outs_t e, g;
        drive(s);
        sb_q.push_back(predict(s, m_md, m_sc));
        @(negedge i_clk);
        g = sample();
        obs_stall = g.stall_d;
        e = sb_q.pop_front();
        compare(tag, g, e);
        @(posedge i_clk);
        advance(s, e.stall_d);
        #1;
    endtask

    task automatic reset_check(input string tag);
        compare(tag, sample(), outs_t'('0));
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        stim_t s;
        int    stalls;

        // Reset with hazards and forwards presented: everything must stay low.
        s = idle();
        s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd8;
        s.id_rs = 5'd8; s.id_use_rs = 1'b1; s.id_redirect = 1'b1; s.id_is_branch = 1'b1;
        s.mem_rd = 5'd8; s.mem_regwrite = 1'b1; s.ex_rs = 5'd8;
        i_rst_n = 1'b0;
        drive(s);
        #3 reset_check("reset");
        #9 i_rst_n = 1'b1;
        drive(idle());
        @(posedge i_clk); #1;
        step(idle(), "idle");

        // Load-use: lw r8 in EX, add r?,r8 in ID; then lw in MEM, add in EX.
        s = idle();
        s.ex_rd = 5'd8; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.id_rs = 5'd8; s.id_use_rs = 1'b1;
        step(s, "load_use");
        s = idle();
        s.mem_rd = 5'd8; s.mem_regwrite = 1'b1; s.mem_memread = 1'b1;
        s.ex_rs = 5'd8; s.ex_rd = 5'd9; s.ex_regwrite = 1'b1;
        s.id_rs = 5'd10; s.id_use_rs = 1'b1;
        step(s, "load_use_fwd");
        // Load-use via rt, and $zero never interlocks.
        s = idle();
        s.ex_rd = 5'd12; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.id_rt = 5'd12; s.id_use_rt = 1'b1;
        step(s, "load_use_rt");
        s.ex_rd = 5'd0; s.id_rt = 5'd0;
        step(s, "load_use_zero");
        s.ex_rd = 5'd12; s.id_rt = 5'd12; s.id_use_rt = 1'b0;
        step(s, "load_use_unused");

        // EX forwarding priority.
        s = idle();
        s.ex_rs = 5'd5; s.ex_rt = 5'd6;
        s.mem_rd = 5'd5; s.mem_regwrite = 1'b1;
        s.wb_rd = 5'd5; s.wb_regwrite = 1'b1;
        step(s, "fwd_mem_prio");
        s.mem_regwrite = 1'b0;
        step(s, "fwd_wb");
        s.ex_rs = 5'd0; s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_regwrite = 1'b1;
        step(s, "fwd_zero");
        s = idle();
        s.ex_rs = 5'd7; s.ex_rt = 5'd6; s.mem_rd = 5'd6; s.mem_regwrite = 1'b1;
        s.wb_rd = 5'd7; s.wb_regwrite = 1'b1;
        step(s, "fwd_split");

        // Branch compare in ID against an ALU producer, then against a load.
        s = idle();
        s.id_is_branch = 1'b1; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
        s.id_rt = 5'd4; s.id_use_rt = 1'b1;
        s.ex_rd = 5'd3; s.ex_regwrite = 1'b1;
        step(s, "br_ex");
        s.ex_rd = 5'd0; s.ex_regwrite = 1'b0;
        s.mem_rd = 5'd3; s.mem_regwrite = 1'b1;
        step(s, "br_mem_fwd");
        s.mem_rd = 5'd4;
        step(s, "br_mem_fwd_rt");
        s = idle();
        s.id_is_branch = 1'b1; s.id_rs = 5'd3; s.id_use_rs = 1'b1;
        s.ex_rd = 5'd3; s.ex_regwrite = 1'b1; s.ex_memread = 1'b1;
        step(s, "br_load_ex");
        s.ex_rd = 5'd0; s.ex_regwrite = 1'b0; s.ex_memread = 1'b0;
        s.mem_rd = 5'd3; s.mem_regwrite = 1'b1; s.mem_memread = 1'b1;
        step(s, "br_load_mem");
        s.mem_rd = 5'd0; s.mem_regwrite = 1'b0; s.mem_memread = 1'b0;
        s.wb_rd = 5'd3; s.wb_regwrite = 1'b1;
        step(s, "br_load_wb");

        // Redirect loses to a stall, then flushes on the retry.
        s = idle();
        s.id_redirect = 1'b1;
        s.ex_rd = 5'd8; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.id_rs = 5'd8; s.id_use_rs = 1'b1;
        step(s, "redir_stall");
        s.ex_rd = 5'd9; s.ex_memread = 1'b0; s.ex_regwrite = 1'b1;
        step(s, "redir_flush");

        // Divide interlock: mflo waits exactly DIV_N cycles.
        s = idle(); s.ex_md_start = 1'b1; s.ex_md_is_div = 1'b1;
        step(s, "div_start");
        s = idle(); s.id_md_use = 1'b1;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            step(s, "div_wait");
            if (obs_stall) stalls++;
            else break;
        end
        check("div_stall_cycles", 32'(stalls), 32'(DIV_N));

        // Multiply interlock; a start arriving while busy must be ignored.
        s = idle(); s.ex_md_start = 1'b1; s.ex_md_is_div = 1'b0;
        step(s, "mult_start");
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.id_md_use = 1'b1;
            if (i < 2) begin s.ex_md_start = 1'b1; s.ex_md_is_div = 1'b1; end
            step(s, "mult_wait");
            if (obs_stall) stalls++;
            else break;
        end
        check("mult_stall_cycles", 32'(stalls), 32'(MULT_N));

        // Reset mid-divide at counter value 17.
        s = idle(); s.ex_md_start = 1'b1; s.ex_md_is_div = 1'b1;
        step(s, "div2_start");
        s = idle(); s.id_md_use = 1'b1;
        for (int i = 0; i < 40 && m_md != 17; i++) step(s, "div2_wait");
        check("div2_reached_17", 32'(m_md), 32'd17);
        s.ex_rd = 5'd8; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.id_rs = 5'd8; s.id_use_rs = 1'b1;
        drive(s);
        #2 i_rst_n = 1'b0;
        #1 reset_check("rst_mid_div");
        m_md = 0;
        m_sc = 0;
        drive(idle());
        @(negedge i_clk); #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        s = idle(); s.id_md_use = 1'b1;
        step(s, "post_rst_mflo");
        check("post_rst_mflo_free", 32'(obs_stall), 32'd0);

        // Stall counter saturation under a held load-use hazard.
        s = idle();
        s.ex_rd = 5'd8; s.ex_memread = 1'b1; s.ex_regwrite = 1'b1;
        s.id_rs = 5'd8; s.id_use_rs = 1'b1;
        drive(s);
        repeat (65534 - m_sc) @(posedge i_clk);
        m_sc = 65534;
        @(negedge i_clk);
        check("sat_fffe", 32'(o_stall_count), 32'h0000_FFFE);
        @(posedge i_clk); #1;
        m_sc = 65535;
        for (int i = 0; i < 3; i++) step(s, "sat_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
